// File: rtl/thirty_two_bit_alu.sv
// 32-bit ALU (AND/OR/ADD/SUB/SLT) with registered result, carry and overflow flags.
// Optional registered zero flag Z when THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN is defined.
module thirty_two_bit_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        Cin,
  input  logic        less,
  input  logic [2:0]  op,
  output logic [31:0] R,
  output logic        Cout,
`ifdef THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN
  output logic        V,
  output logic        Z
`else
  output logic        V
`endif
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [W-1:0] w_b;
  logic [W-1:0] w_sum;
  logic         w_c32;
  logic         w_ovf;
  logic [W-1:0] w_r;
  logic         w_cout;
  logic         w_v;

  logic [W-1:0] r_r;
  logic         r_cout;
  logic         r_v;

  // Shared adder: op[2] selects b inversion; the caller supplies the carry-in.
  always_comb begin
    w_b            = op[2] ? ~b : b;
    {w_c32, w_sum} = (W+1)'(a) + (W+1)'(w_b) + (W+1)'(Cin);
    w_ovf          = (a[W-1] == w_b[W-1]) && (w_sum[W-1] != a[W-1]);
  end

  // Result and flag selection; reserved codes fall through to zeros.
  always_comb begin
    w_r    = '0;
    w_cout = 1'b0;
    w_v    = 1'b0;
    case (op)
      OP_AND: w_r = a & b;
      OP_OR:  w_r = a | b;
      OP_ADD, OP_SUB: begin
        w_r    = w_sum;
        w_cout = w_c32;
        w_v    = w_ovf;
      end
      OP_SLT: begin
        w_r    = {{(W-1){1'b0}}, (less ? ~w_c32 : (w_sum[W-1] ^ w_ovf))};
        w_cout = w_c32;
        w_v    = w_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_cout <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_r    <= w_r;
      r_cout <= w_cout;
      r_v    <= w_v;
    end
  end

  assign R    = r_r;
  assign Cout = r_cout;
  assign V    = r_v;

`ifdef THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN
  logic r_z;

  // Zero flag tracks the value being loaded into r_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_z <= 1'b0;
    else        r_z <= (w_r == '0);
  end

  assign Z = r_z;
`endif

endmodule

// File: tb/tb_thirty_two_bit_alu.sv
// Scoreboard bench for thirty_two_bit_alu: directed vectors, async reset, random traffic.
module tb_thirty_two_bit_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        Cin, less;
  logic [2:0]  op;
  logic [31:0] R;
  logic        Cout, V;
`ifdef THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN
  logic        Z;
`endif

  typedef struct {
    logic [31:0] r;
    logic        cout;
    logic        v;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  thirty_two_bit_alu dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cin(Cin), .less(less), .op(op),
    .R(R), .Cout(Cout),
`ifdef THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN
    .V(V), .Z(Z)
`else
    .V(V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact integer arithmetic, flags from range checks.
  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic icin, input logic iless, input logic [2:0] iop);
    exp_t   e;
    longint ua, ub, sa, sb, du, ds;
    ua = longint'({32'd0, ia});
    ub = longint'({32'd0, ib});
    sa = longint'(signed'(ia));
    sb = longint'(signed'(ib));
    e.r = 32'd0; e.cout = 1'b0; e.v = 1'b0;
    case (iop)
      3'b000: e.r = ia & ib;
      3'b001: e.r = ia | ib;
      3'b010: begin
        du = ua + ub + longint'(icin);
        ds = sa + sb + longint'(icin);
        e.r    = 32'(du);
        e.cout = (du >= 64'sd4294967296);
        e.v    = (ds > 64'sd2147483647) || (ds < -64'sd2147483648);
      end
      3'b110, 3'b111: begin
        du = ua - ub - 1 + longint'(icin);
        ds = sa - sb - 1 + longint'(icin);
        e.cout = (du >= 0);
        e.v    = (ds > 64'sd2147483647) || (ds < -64'sd2147483648);
        if (iop == 3'b110) e.r = 32'(du);
        else               e.r = {31'd0, (iless ? (du < 0) : (ds < 0))};
      end
      default: ;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    logic z_act;
    logic bad;
    n_checks++;
`ifdef THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN
    z_act = Z;
    bad   = (R !== e.r) || (Cout !== e.cout) || (V !== e.v) || (Z !== e.z);
`else
    z_act = e.z;
    bad   = (R !== e.r) || (Cout !== e.cout) || (V !== e.v);
`endif
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got R=%h Cout=%b V=%b Z=%b, expected R=%h Cout=%b V=%b Z=%b",
               name, R, Cout, V, z_act, e.r, e.cout, e.v, e.z);
    end
  endtask

  // Monitor: zeros while in reset, otherwise one scoreboard entry per cycle.
  initial begin
    exp_t e;
    exp_t zero_e;
    zero_e = '{r: 32'd0, cout: 1'b0, v: 1'b0, z: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check_out("reset_hold", zero_e);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_out("result", e);
      end
    end
  end

  task automatic apply(input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic iless, input logic [2:0] iop);
    a = ia; b = ib; Cin = icin; less = iless; op = iop;
    exp_q.push_back(model(ia, ib, icin, iless, iop));
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic iless, input logic [2:0] iop);
    @(negedge clk);
    apply(ia, ib, icin, iless, iop);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        cin, less;
    logic [2:0]  op;
    logic [31:0] r;
    logic        cout, v;
  } vec_t;

  // Directed vectors with hand-derived results.
  vec_t vecs[] = '{
    '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b0},
    '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 3'b010, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 3'b010, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 3'b110, 32'h55555555, 1'b1, 1'b1},
    '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 1'b0, 3'b110, 32'h0001FFFF, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 3'b110, 32'h0001FFFE, 1'b0, 1'b0},
    '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 3'b111, 32'h00000001, 1'b1, 1'b1},
    '{32'h0000FFFF, 32'h0000000F, 1'b1, 1'b0, 3'b111, 32'h00000000, 1'b1, 1'b0},
    '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 3'b111, 32'h00000000, 1'b1, 1'b1},
    '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 3'b010, 32'h00000001, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 3'b010, 32'h80000000, 1'b0, 1'b1},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 3'b011, 32'h00000000, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 3'b100, 32'h00000000, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 3'b101, 32'h00000000, 1'b0, 1'b0}
  };

  logic [2:0] ops[8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b111, 3'b011, 3'b101};

  initial begin
    exp_t m;
    rst_n = 1'b0;
    a = '0; b = '0; Cin = 1'b0; less = 1'b0; op = 3'b000;
    #1;
    check_out("reset_initial", '{r: 32'd0, cout: 1'b0, v: 1'b0, z: 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: confirm the model against hand values, then queue it.
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].less, vecs[i].op);
      n_checks++;
      if (m.r !== vecs[i].r || m.cout !== vecs[i].cout || m.v !== vecs[i].v) begin
        n_fail++;
        $display("FAIL model_vec%0d: got R=%h Cout=%b V=%b, expected R=%h Cout=%b V=%b",
                 i, m.r, m.cout, m.v, vecs[i].r, vecs[i].cout, vecs[i].v);
      end
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].less, vecs[i].op);
    end

    // Async reset while R=FFFFFFFF and an ADD is still in flight.
    issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 3'b001);
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 3'b010);
    #2;
    n_checks++;
    if (R !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL pre_reset_R: got %h, expected FFFFFFFF", R);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_out("async_reset", '{r: 32'd0, cout: 1'b0, v: 1'b0, z: 1'b0});
    repeat (2) begin
      @(negedge clk);
      a = $urandom; b = $urandom; Cin = 1'b1; op = 3'b010;
    end
    // First edge after release captures these inputs.
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h12345678, 32'h11111111, 1'b0, 1'b0, 3'b010);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      issue(ra, rb, 1'($urandom), 1'($urandom), ops[$urandom_range(0, 7)]);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thirty_two_bit_alu.md
THIRTY_TWO_BIT_ALU -- requirements
Module: thirty_two_bit_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports are listed below.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port a, input, 32 bits: operand A.
REQ-005 The block SHALL have port b, input, 32 bits: operand B.
REQ-006 The block SHALL have port Cin, input, 1 bit: adder carry-in into bit 0.
REQ-007 The block SHALL have port less, input, 1 bit: SLT compare mode (0 = signed, 1 = unsigned).
REQ-008 The block SHALL have port op, input, 3 bits: operation select.
REQ-009 The block SHALL have port R, output, 32 bits: registered result.
REQ-010 The block SHALL have port Cout, output, 1 bit: registered carry out of bit 31.
REQ-011 The block SHALL have port V, output, 1 bit: registered signed-overflow flag.

Function
REQ-012 The block SHALL use this op encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; 011/100/101 are reserved.
REQ-013 The internal adder SHALL compute a + (op[2] ? ~b : b) + Cin over 32 bits, producing sum[31:0] and carry c32.
- SUB with Cin=0 gives a-b-1.
- The block SHALL NOT force the carry-in internally.
REQ-014 AND SHALL give R = a & b, Cout = 0, V = 0.
REQ-015 OR SHALL give R = a | b, Cout = 0, V = 0.
REQ-016 ADD and SUB SHALL give R = sum, Cout = c32, and V = (a[31] == b'[31]) && (sum[31] != a[31]), where b' is the possibly-inverted b.
REQ-017 SLT SHALL give R[31:1] = 0, with Cout and V as for SUB.
- less=0 (signed): R[0] = sum[31] XOR V.
- less=1 (unsigned): R[0] = ~c32.
REQ-018 The less input SHALL be ignored for every op other than SLT.
REQ-019 Reserved op codes SHALL give R = 0, Cout = 0, V = 0.
REQ-020 Outputs SHALL be registered on the rising clk edge, with latency of exactly 1 cycle from inputs to R, Cout and V.
REQ-021 The block SHALL accept a new operation every cycle, with no handshake or stall.
REQ-022 Arithmetic SHALL wrap modulo 2^32 and never saturate.
- The carry beyond c32 SHALL be discarded.

Reset
REQ-023 While rst_n = 0, R SHALL be 0, Cout SHALL be 0 and V SHALL be 0, asynchronously and regardless of clk.
REQ-024 Assertion of rst_n mid-operation SHALL discard the pending result.
REQ-025 After rst_n deasserts, the first clk rising edge SHALL capture the current inputs.

Configuration
REQ-026 When THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN is defined, the block SHALL add output port Z, 1 bit.
- Z SHALL be registered alongside R, equal 1 when the registered R is 0, and reset to 0.
REQ-027 When THIRTY_TWO_BIT_ALU_ZERO_FLAG_EN is undefined, port Z and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-028 AND: op=000, a=AAAAAAAA, b=55555555 -> R=00000000, Cout=0, V=0; a=0000FFFF, b=FFFF0000 -> R=00000000.
REQ-029 OR: op=001, a=AAAAAAAA, b=55555555 -> R=FFFFFFFF; a=0000FFFF, b=FFFF0000 -> R=FFFFFFFF; Cout=0, V=0 in both cases.
REQ-030 ADD: op=010, Cin=0.
- a=AAAAAAAA, b=55555555 -> R=FFFFFFFF, Cout=0, V=0.
- a=0000FFFF, b=FFFF0000 -> R=FFFFFFFF, Cout=0, V=0.
REQ-031 SUB: op=110, Cin=1.
- a=AAAAAAAA, b=55555555 -> R=55555555, Cout=1, V=1.
- a=0000FFFF, b=FFFF0000 -> R=0001FFFF, Cout=0, V=0.
REQ-032 SLT: op=111, Cin=1.
- less=0, a=AAAAAAAA, b=55555555 -> R=00000001, Cout=1, V=1.
- less=0, a=0000FFFF, b=0000000F -> R=00000000, Cout=1, V=0.
- less=1, a=AAAAAAAA, b=55555555 -> R=00000000.
REQ-033 Reset and latency:
- Drive rst_n low while R=FFFFFFFF -> R, Cout and V go to 0 immediately, without waiting for a clock edge.
- Release rst_n, then apply an ADD on cycle N -> the result appears after clk edge N+1.
- Any reserved op -> all outputs 0.
